instr_fetch: RTL and testbench

//  Instruction fetch/prefetch stage feeding the instruction decoder. Drives ROM reads

---
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: ROM read port, redirect input, decoder handshake and debug state.
// Handshake: a word transfers on a clock edge where ir_valid && ir_ready; ir_valid never waits on ir_ready.
interface instr_fetch_if;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] ir_word;
    logic [15:0] ir_addr;
    logic        ir_is_ext;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] fetch_pc;
    logic [1:0]  fsm_state;

    modport master (
        output rom_rd, rom_addr, ir_word, ir_addr, ir_is_ext, ir_valid, fetch_pc, fsm_state,
        input  rom_data, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  rom_rd, rom_addr, ir_word, ir_addr, ir_is_ext, ir_valid, fetch_pc, fsm_state,
        output rom_data, redirect, redirect_pc, ir_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/prefetch stage: ROM reads into a small FIFO, opcode/extension tagging.
// Optional IFETCH_RESET_VECTOR_EN: fetch the start PC from the reset vector at 16'hFFFE.
module instr_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'hC000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_VEC_REQ  = 2'd0,
        S_VEC_WAIT = 2'd1,
        S_RUN      = 2'd2
    } state_t;

`ifdef IFETCH_RESET_VECTOR_EN
    localparam state_t      INIT_STATE = S_VEC_REQ;
    localparam logic [15:0] INIT_PC    = 16'hFFFE;
`else
    localparam state_t      INIT_STATE = S_RUN;
    localparam logic [15:0] INIT_PC    = RESET_PC;
`endif

    state_t          state;
    logic [15:0]     fetch_pc;
    logic [15:0]     pend_addr;
    logic            inflight;
    logic [AW:0]     count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [1:0]      ext_left;
    logic [15:0]     word_mem [DEPTH];
    logic [15:0]     addr_mem [DEPTH];

    logic            take_redirect;
    logic            issue;
    logic            push;
    logic            pop;
    logic [AW:0]     occupancy;

    // Number of extension words that follow an opcode.
    function automatic logic [1:0] ext_count(input logic [15:0] op);
        logic [3:0] rs;
        logic [1:0] as_f;
        logic       src_ext;
        as_f    = op[5:4];
        rs      = (op[15:12] == 4'h1) ? op[3:0] : op[11:8];
        src_ext = (as_f == 2'b01 && rs != 4'd3) || (as_f == 2'b11 && rs == 4'd0);
        if (op[15:12] >= 4'h4)
            ext_count = {1'b0, src_ext} + {1'b0, op[7]};
        else if (op[15:12] == 4'h1)
            ext_count = {1'b0, src_ext};
        else
            ext_count = 2'd0;
    endfunction

    always_comb begin
        occupancy     = count + {{AW{1'b0}}, inflight};
        take_redirect = (state == S_RUN) && bus.redirect;
        issue         = (state == S_RUN) && !bus.redirect && (occupancy < DEPTH_C);
        push          = inflight && !take_redirect;
        pop           = (count != '0) && bus.ir_ready && !take_redirect;
    end

    // rom_rd is gated by rst so it drops the instant reset is asserted.
    assign bus.rom_rd    = !rst && (issue || state == S_VEC_REQ);
    assign bus.rom_addr  = fetch_pc;
    assign bus.fetch_pc  = fetch_pc;
    assign bus.ir_word   = word_mem[rd_ptr];
    assign bus.ir_addr   = addr_mem[rd_ptr];
    assign bus.ir_valid  = (count != '0);
    assign bus.ir_is_ext = (ext_left != 2'd0);
    assign bus.fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT_STATE;
            fetch_pc  <= INIT_PC;
            pend_addr <= 16'h0000;
            inflight  <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            ext_left  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                word_mem[i] <= 16'h0000;
                addr_mem[i] <= 16'h0000;
            end
        end else begin
            case (state)
                S_VEC_REQ: state <= S_VEC_WAIT;
                S_VEC_WAIT: begin
                    fetch_pc <= bus.rom_data & 16'hFFFE;
                    state    <= S_RUN;
                end
                default: begin
                    if (take_redirect) begin
                        fetch_pc <= bus.redirect_pc & 16'hFFFE;
                        inflight <= 1'b0;
                        count    <= '0;
                        rd_ptr   <= '0;
                        wr_ptr   <= '0;
                        ext_left <= 2'd0;
                    end else begin
                        inflight <= issue;
                        if (issue) begin
                            pend_addr <= fetch_pc;
                            fetch_pc  <= fetch_pc + 16'd2;
                        end
                        if (push) begin
                            word_mem[wr_ptr] <= bus.rom_data;
                            addr_mem[wr_ptr] <= pend_addr;
                            wr_ptr           <= wr_ptr + AW'(1);
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + AW'(1);
                            if (ext_left == 2'd0)
                                ext_left <= ext_count(word_mem[rd_ptr]);
                            else
                                ext_left <= ext_left - 2'd1;
                        end
                        if (push && !pop)
                            count <= count + (AW+1)'(1);
                        else if (pop && !push)
                            count <= count - (AW+1)'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM model, table of tagged program words, scoreboard of expected words.
module tb_instr_fetch;
    localparam int W     = 33;
    localparam int DEPTH = 2;

`ifdef IFETCH_RESET_VECTOR_EN
    localparam logic [15:0] START_PC = 16'hFFFE;
    localparam bit          VEC      = 1'b1;
`else
    localparam logic [15:0] START_PC = 16'hC000;
    localparam bit          VEC      = 1'b0;
`endif

    typedef struct {
        logic [15:0] word;
        logic        ext;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if bus();
    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(16'hC000)) dut (.clk(clk), .rst(rst), .bus(bus));

    vec_t          tab [16];
    logic [W-1:0]  exp_q [$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [15:0]   model_pc;
    bit            vec_skip;
    int            first_rd_cyc;
    int            first_valid_cyc;

    logic          s_rd, s_valid, s_ext, popped, last_ext;
    logic [15:0]   s_addr, s_word, s_iaddr, last_word, last_addr;

    function automatic logic [15:0] rom(input logic [15:0] a);
        int idx;
        if (a == 16'hFFFE) return 16'hC000;
        if (a >= 16'hC000 && a < 16'hC020) begin
            idx = int'((a - 16'hC000) >> 1);
            return tab[idx].word;
        end
        return {3'b001, a[13:1]};
    endfunction

    function automatic logic exp_ext(input logic [15:0] a);
        int idx;
        if (a >= 16'hC000 && a < 16'hC020) begin
            idx = int'((a - 16'hC000) >> 1);
            return tab[idx].ext;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (bus.rom_rd) bus.rom_data <= rom(bus.rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string act, input string req);
        checks++;
        failures++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endtask

    task automatic reset_model();
        exp_q.delete();
        model_pc        = START_PC;
        vec_skip        = VEC;
        first_rd_cyc    = -1;
        first_valid_cyc = -1;
        cyc             = 0;
    endtask

    // Samples at negedge, updates the scoreboard, then advances to just past the next posedge.
    task automatic cycle();
        logic [W-1:0] e;
        @(negedge clk);
        s_rd    = bus.rom_rd;
        s_addr  = bus.rom_addr;
        s_valid = bus.ir_valid;
        s_word  = bus.ir_word;
        s_iaddr = bus.ir_addr;
        s_ext   = bus.ir_is_ext;
        popped  = 1'b0;
        if (!rst) begin
            if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_rd) begin
                chk("rom_addr", s_addr, model_pc);
                if (vec_skip) begin
                    vec_skip = 1'b0;
                    model_pc = rom(16'hFFFE) & 16'hFFFE;
                end else begin
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                    exp_q.push_back({exp_ext(model_pc), model_pc, rom(model_pc)});
                    model_pc = model_pc + 16'd2;
                end
            end
            if (bus.redirect) begin
                chk("rd_during_redirect", {31'b0, s_rd}, 32'd0);
                exp_q.delete();
                model_pc = bus.redirect_pc & 16'hFFFE;
            end else if (s_valid && bus.ir_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_word", $sformatf("%h", s_word), "none");
                end else begin
                    e = exp_q.pop_front();
                    chk("ir_word", s_word, e[15:0]);
                    chk("ir_addr", s_iaddr, e[31:16]);
                    chk("ir_is_ext", s_ext, e[32]);
                end
                popped    = 1'b1;
                last_word = s_word;
                last_addr = s_iaddr;
                last_ext  = s_ext;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_pop(input string name);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!popped && n < 12);
        if (!popped) fail_now({name, "_timeout"}, "no_pop", "pop");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        int n;
        int k;
        logic [15:0] wa [3];

        tab[0]  = '{16'h40B2, 1'b0};
        tab[1]  = '{16'h1234, 1'b1};
        tab[2]  = '{16'h0200, 1'b1};
        tab[3]  = '{16'h4303, 1'b0};
        tab[4]  = '{16'h4154, 1'b0};
        tab[5]  = '{16'h0004, 1'b1};
        tab[6]  = '{16'h1290, 1'b0};
        tab[7]  = '{16'h0010, 1'b1};
        tab[8]  = '{16'h4392, 1'b0};
        tab[9]  = '{16'h0202, 1'b1};
        tab[10] = '{16'h403F, 1'b0};
        tab[11] = '{16'h5555, 1'b1};
        tab[12] = '{16'h2400, 1'b0};
        tab[13] = '{16'h0030, 1'b0};
        tab[14] = '{16'h4130, 1'b0};
        tab[15] = '{16'h4303, 1'b0};

        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.ir_ready    = 1'b0;
        reset_model();
        cycle();
        cycle();
        chk("reset_rom_rd", {31'b0, bus.rom_rd}, 32'd0);
        chk("reset_ir_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("reset_ir_is_ext", {31'b0, bus.ir_is_ext}, 32'd0);
        chk("reset_ir_word", bus.ir_word, 32'h0);
        chk("reset_fetch_pc", bus.fetch_pc, START_PC);

        // Startup, vector (if enabled) and tagging over the program table.
        rst          = 1'b0;
        bus.ir_ready = 1'b1;
        reset_model();
        for (int i = 0; i < 16; i++) begin
            wait_pop("tab");
            chk("tab_word", last_word, tab[i].word);
            chk("tab_ext", last_ext, tab[i].ext);
            chk("tab_addr", last_addr, 16'hC000 + 16'(2 * i));
        end
        chk("first_rd_cycle", first_rd_cyc, VEC ? 32'd2 : 32'd0);
        chk("first_valid_latency", first_valid_cyc - first_rd_cyc, 32'd2);

        // Back-pressure after a flush: only DEPTH reads, head holds still, nothing lost.
        bus.ir_ready    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hC100;
        cycle();
        bus.redirect = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            rd_cnt += int'(s_rd);
        end
        chk("bp_reads", rd_cnt, DEPTH);
        chk("bp_rom_rd_idle", {31'b0, s_rd}, 32'd0);
        chk("bp_ir_valid", {31'b0, s_valid}, 32'd1);
        chk("bp_ir_word", s_word, rom(16'hC100));
        chk("bp_ir_addr", s_iaddr, 16'hC100);
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_pop("bp");
            chk("bp_order", last_addr, 16'hC100 + 16'(2 * i));
        end

        // Redirect with a read in flight.
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_rd && n < 6);
        if (!s_rd) fail_now("redir_wait_rd", "no_rd", "rd");
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hC101;
        cycle();
        bus.redirect = 1'b0;
        cycle();
        chk("redir_issue", {31'b0, s_rd}, 32'd1);
        chk("redir_addr", s_addr, 16'hC100);
        chk("redir_valid_c1", {31'b0, s_valid}, 32'd0);
        cycle();
        chk("redir_valid_c2", {31'b0, s_valid}, 32'd0);
        cycle();
        chk("redir_valid_c3", {31'b0, s_valid}, 32'd1);
        chk("redir_head_addr", s_iaddr, 16'hC100);

        // PC wrap at the top of the address space.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFC;
        cycle();
        bus.redirect = 1'b0;
        for (int i = 0; i < 3; i++) wa[i] = 16'h1111;
        k = 0;
        n = 0;
        while (k < 3 && n < 12) begin
            cycle();
            n++;
            if (s_rd) begin
                wa[k] = s_addr;
                k++;
            end
        end
        chk("wrap_addr0", wa[0], 16'hFFFC);
        chk("wrap_addr1", wa[1], 16'hFFFE);
        chk("wrap_addr2", wa[2], 16'h0000);
        repeat (6) cycle();

        // Asynchronous reset between edges, then restart.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rom_rd", {31'b0, bus.rom_rd}, 32'd0);
        chk("async_ir_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("async_fetch_pc", bus.fetch_pc, START_PC);
        cycle();
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 6; i++) begin
            wait_pop("restart");
            chk("restart_word", last_word, tab[i].word);
            chk("restart_ext", last_ext, tab[i].ext);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
